// File: rtl/vending_dispense_ctrl.sv
// Keypad-driven multi-slot spiral dispenser: debounced slot/quantity entry,
// one relay per slot, rotation counting on a sensor pair and jam timeout.
module vending_dispense_ctrl #(
    parameter int NUM_CH     = 4,
    parameter int MAX_QTY    = 9,
    parameter int DEBOUNCE   = 15,
    parameter int SENSOR_CYC = 15,
    parameter int TIMEOUT    = 5000000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [2:0]        coluna,
    input  logic [3:0]        linha,
    input  logic              sensor1,
    input  logic              sensor2,
    output logic [NUM_CH-1:0] rele,
    output logic              busy,
    output logic              fault,
    output logic              done,
    output logic [3:0]        slot_sel,
    output logic [3:0]        qty_left
);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int SW = $clog2(SENSOR_CYC + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE);
    localparam logic [SW-1:0] S_MAX   = SW'(SENSOR_CYC);
    localparam logic [TW-1:0] T_MAX   = TW'(TIMEOUT);
    localparam logic [3:0]    CH_MAX  = 4'(NUM_CH);
    localparam logic [3:0]    QTY_MAX = 4'(MAX_QTY);
    localparam logic [3:0]    KEY_STAR = 4'd10;
    localparam logic [3:0]    KEY_HASH = 4'd11;

    typedef enum logic [2:0] {
        S_IDLE, S_GOT_SLOT, S_GOT_QTY, S_DISPENSE, S_FAULT
    } state_t;

    state_t            state, state_nxt;
    logic [6:0]        sample, last;
    logic              sample_ok, armed, key_evt;
    logic [DW-1:0]     db_cnt;
    logic [1:0]        row_idx, col_idx;
    logic [3:0]        key_code;
    logic              both, rot_hit;
    logic [SW-1:0]     s_cnt;
    logic [TW-1:0]     t_cnt, t_nxt;
    logic [3:0]        slot_q, slot_nxt, qty_q, qty_nxt;
    logic              done_q, done_nxt;
    logic [NUM_CH-1:0] rele_q, rele_nxt;
    logic              is_star, is_hash, is_digit;

    function automatic logic onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    assign sample    = {coluna, linha};
    assign sample_ok = onehot4({1'b0, coluna}) && onehot4(linha);
    // Event fires on the edge where the run of identical samples reaches DEBOUNCE
    assign key_evt   = sample_ok && (sample == last) && armed && (db_cnt == DB_MAX - DW'(1));

    always_comb begin
        row_idx = 2'd3;
        if (linha[3])      row_idx = 2'd0;
        else if (linha[2]) row_idx = 2'd1;
        else if (linha[1]) row_idx = 2'd2;
        col_idx = 2'd2;
        if (coluna[2])      col_idx = 2'd0;
        else if (coluna[1]) col_idx = 2'd1;
        if (row_idx != 2'd3)      key_code = {2'b00, row_idx} * 4'd3 + {2'b00, col_idx} + 4'd1;
        else if (col_idx == 2'd0) key_code = KEY_STAR;
        else if (col_idx == 2'd1) key_code = 4'd0;
        else                      key_code = KEY_HASH;
    end

    // A new press is only accepted after at least one no-key sample
    always_ff @(posedge clock) begin
        if (reset) begin
            last   <= '0;
            db_cnt <= '0;
            armed  <= 1'b1;
        end else begin
            last <= sample;
            if (!sample_ok) begin
                db_cnt <= '0;
                armed  <= 1'b1;
            end else if (sample != last) begin
                db_cnt <= '0;
            end else if (db_cnt != DB_MAX) begin
                db_cnt <= db_cnt + DW'(1);
            end
            if (key_evt) armed <= 1'b0;
        end
    end

    assign both    = sensor1 & sensor2;
    assign rot_hit = both && (s_cnt == S_MAX - SW'(1));

    always_ff @(posedge clock) begin
        if (reset)                s_cnt <= '0;
        else if (!both)           s_cnt <= '0;
        else if (s_cnt != S_MAX)  s_cnt <= s_cnt + SW'(1);
    end

    assign is_star  = key_evt && (key_code == KEY_STAR);
    assign is_hash  = key_evt && (key_code == KEY_HASH);
    assign is_digit = key_evt && (key_code <= 4'd9);

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= S_IDLE;
            slot_q <= '0;
            qty_q  <= '0;
            t_cnt  <= '0;
            done_q <= 1'b0;
            rele_q <= '0;
        end else begin
            state  <= state_nxt;
            slot_q <= slot_nxt;
            qty_q  <= qty_nxt;
            t_cnt  <= t_nxt;
            done_q <= done_nxt;
            rele_q <= rele_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        slot_nxt  = slot_q;
        qty_nxt   = qty_q;
        t_nxt     = t_cnt;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (is_digit && key_code != 4'd0 && key_code <= CH_MAX) begin
                    slot_nxt  = key_code;
                    state_nxt = S_GOT_SLOT;
                end
            end
            S_GOT_SLOT: begin
                if (is_star) begin
                    slot_nxt  = '0;
                    state_nxt = S_IDLE;
                end else if (is_digit && key_code != 4'd0 && key_code <= QTY_MAX) begin
                    qty_nxt   = key_code;
                    state_nxt = S_GOT_QTY;
                end
            end
            S_GOT_QTY: begin
                if (is_hash) begin
                    t_nxt     = '0;
                    state_nxt = S_DISPENSE;
                end else if (is_star) begin
                    slot_nxt  = '0;
                    qty_nxt   = '0;
                    state_nxt = S_IDLE;
                end
            end
            S_DISPENSE: begin
                // Abort beats rotation, rotation beats timeout
                if (is_star) begin
                    slot_nxt  = '0;
                    qty_nxt   = '0;
                    state_nxt = S_IDLE;
                end else if (rot_hit) begin
                    t_nxt   = '0;
                    qty_nxt = qty_q - 4'd1;
                    if (qty_q == 4'd1) begin
                        slot_nxt  = '0;
                        done_nxt  = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end else if (t_cnt == T_MAX - TW'(1)) begin
                    t_nxt     = T_MAX;
                    state_nxt = S_FAULT;
                end else begin
                    t_nxt = t_cnt + TW'(1);
                end
            end
            S_FAULT: begin
                if (is_star) begin
                    slot_nxt  = '0;
                    qty_nxt   = '0;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        for (int k = 0; k < NUM_CH; k++)
            rele_nxt[k] = (state_nxt == S_DISPENSE) && (slot_nxt == 4'(k + 1));
    end

    always_comb begin
        busy     = (state == S_DISPENSE);
        fault    = (state == S_FAULT);
        rele     = rele_q;
        done     = done_q;
        slot_sel = slot_q;
        qty_left = qty_q;
    end
endmodule

// File: tb/tb_vending_dispense_ctrl.sv
// Bench for vending_dispense_ctrl: directed scenarios plus random keypad/sensor
// traffic, all compared against a run-length based reference model.
module tb_vending_dispense_ctrl;
    localparam int NUM_CH = 4, MAX_QTY = 9, DEBOUNCE = 3, SENSOR_CYC = 3, TIMEOUT = 50;
    localparam int MD_IDLE = 0, MD_SLOT = 1, MD_QTY = 2, MD_DISP = 3, MD_FAULT = 4;
    localparam int K_STAR = 10, K_HASH = 11, K_NONE = -1;

    logic clock = 1'b0, reset = 1'b1;
    logic [2:0] coluna = 3'b000;
    logic [3:0] linha = 4'b0000;
    logic sensor1 = 1'b0, sensor2 = 1'b0;
    logic [NUM_CH-1:0] rele;
    logic busy, fault, done;
    logic [3:0] slot_sel, qty_left;
    logic [14:0] dut_out;
    int checks = 0, errors = 0;
    int lut[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};

    int m_mode, m_slot, m_qty, m_since, m_srun, m_run, m_armed;
    logic [6:0] m_prev;
    bit m_done;

    always #5 clock = ~clock;

    vending_dispense_ctrl #(.NUM_CH(NUM_CH), .MAX_QTY(MAX_QTY), .DEBOUNCE(DEBOUNCE),
                            .SENSOR_CYC(SENSOR_CYC), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .coluna(coluna), .linha(linha),
        .sensor1(sensor1), .sensor2(sensor2), .rele(rele), .busy(busy),
        .fault(fault), .done(done), .slot_sel(slot_sel), .qty_left(qty_left)
    );

    assign dut_out = {rele, busy, fault, done, slot_sel, qty_left};

    function automatic logic [14:0] model_out();
        logic [3:0] r;
        r = 4'b0000;
        if (m_mode == MD_DISP) r[m_slot - 1] = 1'b1;
        return {r, m_mode == MD_DISP, m_mode == MD_FAULT, m_done, 4'(m_slot), 4'(m_qty)};
    endfunction

    function automatic int decode(input logic [6:0] s);
        int row, col;
        row = 0;
        col = 0;
        for (int i = 0; i < 4; i++) if (s[3 - i]) row = i;
        for (int i = 0; i < 3; i++) if (s[6 - i]) col = i;
        return lut[row * 3 + col];
    endfunction

    task automatic model_reset();
        m_mode = MD_IDLE; m_slot = 0; m_qty = 0; m_since = 0; m_done = 0;
        m_srun = 0; m_run = 0; m_armed = 1; m_prev = '0;
    endtask

    // Advance the model by one clock edge using the inputs now applied, then clock the DUT.
    task automatic step();
        logic [6:0] s;
        bit valid, both, rot;
        int k;
        s = {coluna, linha};
        valid = ($countones(coluna) == 1) && ($countones(linha) == 1);
        both = sensor1 && sensor2;
        if (reset) begin
            model_reset();
        end else begin
            k = K_NONE;
            if (valid) m_run = (s == m_prev) ? m_run + 1 : 1;
            else m_run = 0;
            if (m_run > 100) m_run = 100;
            if (valid && m_armed != 0 && m_run == DEBOUNCE + 1) begin
                k = decode(s);
                m_armed = 0;
            end
            if (!valid) m_armed = 1;
            m_prev = s;
            m_srun = both ? m_srun + 1 : 0;
            rot = (m_srun == SENSOR_CYC);
            if (m_srun > 100) m_srun = 100;
            m_done = 0;
            case (m_mode)
                MD_IDLE: if (k >= 1 && k <= NUM_CH) begin m_slot = k; m_mode = MD_SLOT; end
                MD_SLOT: begin
                    if (k == K_STAR) begin m_slot = 0; m_mode = MD_IDLE; end
                    else if (k >= 1 && k <= MAX_QTY) begin m_qty = k; m_mode = MD_QTY; end
                end
                MD_QTY: begin
                    if (k == K_HASH) begin m_since = 0; m_mode = MD_DISP; end
                    else if (k == K_STAR) begin m_slot = 0; m_qty = 0; m_mode = MD_IDLE; end
                end
                MD_DISP: begin
                    if (k == K_STAR) begin
                        m_slot = 0; m_qty = 0; m_mode = MD_IDLE;
                    end else if (rot) begin
                        m_since = 0;
                        m_qty--;
                        if (m_qty == 0) begin m_slot = 0; m_done = 1; m_mode = MD_IDLE; end
                    end else begin
                        m_since++;
                        if (m_since >= TIMEOUT) m_mode = MD_FAULT;
                    end
                end
                default: if (k == K_STAR) begin m_slot = 0; m_qty = 0; m_mode = MD_IDLE; end
            endcase
        end
        @(posedge clock);
        #1;
    endtask

    task automatic set_key(input int k);
        coluna = 3'b000;
        linha = 4'b0000;
        for (int p = 0; p < 12; p++)
            if (lut[p] == k) begin
                linha = 4'b1000 >> (p / 3);
                coluna = 3'b100 >> (p % 3);
            end
    endtask

    task automatic press(input int k, input int hold, input int gap);
        set_key(k);
        repeat (hold) step();
        set_key(K_NONE);
        repeat (gap) step();
    endtask

    task automatic do_reset();
        set_key(K_NONE);
        sensor1 = 1'b0; sensor2 = 1'b0;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (dut_out !== 15'd0) begin errors++; $display("FAIL reset_outputs: got %h expected 0000", dut_out); end
        checks++;
        if (dut_out !== model_out()) begin errors++; $display("FAIL reset_model: got %h expected %h", dut_out, model_out()); end
    endtask

    task automatic test_key_event();
        set_key(2);
        repeat (3) step();
        checks++;
        if (slot_sel !== 4'd0) begin errors++; $display("FAIL key_early: got %0d expected 0", slot_sel); end
        step();
        checks++;
        if (slot_sel !== 4'd2) begin errors++; $display("FAIL key_slot2: got %0d expected 2", slot_sel); end
        repeat (8) step();
        checks++;
        if (qty_left !== 4'd0 || slot_sel !== 4'd2) begin
            errors++; $display("FAIL key_hold_single: got slot %0d qty %0d expected slot 2 qty 0", slot_sel, qty_left);
        end
        checks++;
        if (dut_out !== model_out()) begin errors++; $display("FAIL key_model: got %h expected %h", dut_out, model_out()); end
        set_key(K_NONE);
        step();
    endtask

    task automatic test_dispense();
        do_reset();
        press(2, 5, 2); press(3, 5, 2); press(K_HASH, 5, 2);
        checks++;
        if (rele !== 4'b0010 || busy !== 1'b1 || qty_left !== 4'd3) begin
            errors++; $display("FAIL disp_start: got rele %b busy %b qty %0d expected 0010 1 3", rele, busy, qty_left);
        end
        for (int p = 0; p < 3; p++) begin
            sensor1 = 1'b1; sensor2 = 1'b1;
            for (int c = 0; c < 3; c++) begin
                step();
                checks++;
                if (dut_out !== model_out()) begin
                    errors++; $display("FAIL disp_pulse%0d_c%0d: got %h expected %h", p, c, dut_out, model_out());
                end
            end
            checks++;
            if (qty_left !== 4'(2 - p)) begin errors++; $display("FAIL disp_qty%0d: got %0d expected %0d", p, qty_left, 2 - p); end
            if (p == 2) begin
                checks++;
                if (done !== 1'b1 || rele !== 4'b0000 || busy !== 1'b0 || slot_sel !== 4'd0) begin
                    errors++; $display("FAIL disp_done: got done %b rele %b busy %b slot %0d expected 1 0000 0 0", done, rele, busy, slot_sel);
                end
            end else begin
                checks++;
                if (done !== 1'b0 || rele !== 4'b0010) begin errors++; $display("FAIL disp_mid%0d: got done %b rele %b expected 0 0010", p, done, rele); end
            end
            sensor1 = 1'b0; sensor2 = 1'b0;
            step(); step();
        end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL disp_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_ignored();
        do_reset();
        press(7, 5, 2);
        checks++;
        if (slot_sel !== 4'd0) begin errors++; $display("FAIL ign_key7: got %0d expected 0", slot_sel); end
        press(2, 5, 2); press(0, 5, 2);
        checks++;
        if (slot_sel !== 4'd2 || qty_left !== 4'd0) begin errors++; $display("FAIL ign_key0: got slot %0d qty %0d expected 2 0", slot_sel, qty_left); end
        coluna = 3'b010; linha = 4'b1100;
        repeat (8) step();
        set_key(K_NONE);
        step(); step();
        checks++;
        if (qty_left !== 4'd0) begin errors++; $display("FAIL ign_multibit: got %0d expected 0", qty_left); end
        press(5, 5, 2);
        checks++;
        if (qty_left !== 4'd5) begin errors++; $display("FAIL ign_then_qty: got %0d expected 5", qty_left); end
        press(K_STAR, 5, 2);
        checks++;
        if (dut_out !== 15'd0 || dut_out !== model_out()) begin errors++; $display("FAIL ign_star_clear: got %h expected 0000", dut_out); end
    endtask

    task automatic test_timeout();
        int first;
        first = -1;
        do_reset();
        press(1, 5, 2); press(2, 5, 2); press(K_HASH, 5, 2);
        for (int i = 1; i <= 50; i++) begin
            step();
            if (fault === 1'b1 && first < 0) first = i;
            checks++;
            if (dut_out !== model_out()) begin errors++; $display("FAIL tmo_cycle%0d: got %h expected %h", i, dut_out, model_out()); end
        end
        checks++;
        if (first != TIMEOUT - 3) begin errors++; $display("FAIL tmo_latency: got %0d expected %0d", first, TIMEOUT - 3); end
        checks++;
        if (fault !== 1'b1 || rele !== 4'b0000 || busy !== 1'b0 || qty_left !== 4'd2) begin
            errors++; $display("FAIL tmo_state: got fault %b rele %b busy %b qty %0d expected 1 0000 0 2", fault, rele, busy, qty_left);
        end
        press(K_STAR, 5, 2);
        checks++;
        if (fault !== 1'b0 || slot_sel !== 4'd0 || qty_left !== 4'd0) begin
            errors++; $display("FAIL tmo_clear: got fault %b slot %0d qty %0d expected 0 0 0", fault, slot_sel, qty_left);
        end
    endtask

    task automatic test_star_vs_rotation();
        do_reset();
        press(3, 5, 2); press(1, 5, 2); press(K_HASH, 5, 2);
        set_key(K_STAR);
        step();
        sensor1 = 1'b1; sensor2 = 1'b1;
        repeat (3) step();
        checks++;
        if (rele !== 4'b0000 || done !== 1'b0 || busy !== 1'b0 || qty_left !== 4'd0) begin
            errors++; $display("FAIL star_rot: got rele %b done %b busy %b qty %0d expected 0000 0 0 0", rele, done, busy, qty_left);
        end
        checks++;
        if (dut_out !== model_out()) begin errors++; $display("FAIL star_rot_model: got %h expected %h", dut_out, model_out()); end
        sensor1 = 1'b0; sensor2 = 1'b0;
        set_key(K_NONE);
        step();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL star_rot_nodone: got %b expected 0", done); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        press(3, 5, 2); press(3, 5, 2); press(K_HASH, 5, 2);
        reset = 1'b1;
        step();
        checks++;
        if (rele !== 4'b0000 || busy !== 1'b0 || qty_left !== 4'd0) begin
            errors++; $display("FAIL reset_mid: got rele %b busy %b qty %0d expected 0000 0 0", rele, busy, qty_left);
        end
        reset = 1'b0;
        step();
        press(4, 5, 2); press(1, 5, 2); press(K_HASH, 5, 2);
        for (int g = 0; g < 3; g++) begin
            sensor1 = 1'b1; sensor2 = 1'b1;
            step(); step();
            sensor1 = 1'b0;
            step(); step();
            checks++;
            if (dut_out !== model_out()) begin errors++; $display("FAIL glitch%0d_model: got %h expected %h", g, dut_out, model_out()); end
        end
        sensor2 = 1'b0;
        checks++;
        if (qty_left !== 4'd1 || rele !== 4'b1000) begin errors++; $display("FAIL glitch: got qty %0d rele %b expected 1 1000", qty_left, rele); end
        press(K_STAR, 5, 2);
    endtask

    task automatic test_random();
        int key_left, sens_left, r;
        key_left = 0;
        sens_left = 0;
        for (int c = 0; c < 3000; c++) begin
            if (key_left == 0) begin
                key_left = $urandom_range(1, 7);
                r = $urandom_range(0, 19);
                if (r < 9) set_key(r + 1);
                else if (r < 12) set_key(K_HASH);
                else if (r == 12) set_key(K_STAR);
                else if (r == 13) set_key(0);
                else if (r < 18) set_key(K_NONE);
                else begin coluna = 3'($urandom_range(0, 7)); linha = 4'($urandom_range(0, 15)); end
            end
            if (sens_left == 0) begin
                sens_left = $urandom_range(1, 5);
                r = $urandom_range(0, 3);
                sensor1 = (r < 2) || (r == 2 && $urandom_range(0, 1) == 1);
                sensor2 = (r < 2);
            end
            key_left--;
            sens_left--;
            reset = ($urandom_range(0, 399) == 0);
            step();
            checks++;
            if (dut_out !== model_out()) begin errors++; $display("FAIL random_c%0d: got %h expected %h", c, dut_out, model_out()); end
        end
        reset = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_key_event();
        test_dispense();
        test_ignored();
        test_timeout();
        test_star_vs_rotation();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
